// File: rtl/aidc_lite_pkg.sv
// Shared types and constants for the AIDC-Lite code buffer path.
package aidc_lite_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    DECIDE = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam int CODE_WORD_W = 64;
  localparam int LINE_W      = 512;

  // Code prefix shared with the concatenator's word format
  localparam logic [1:0] CC_PREFIX = 2'b11;

  function automatic logic [CODE_WORD_W-1:0] raw_word(
    input logic [LINE_W-1:0] line,
    input logic [2:0]        idx
  );
    return line[int'(idx)*CODE_WORD_W +: CODE_WORD_W];
  endfunction

endpackage

// File: rtl/aidc_lite_word_buf.sv
// Code-word register file: one synchronous write port, one combinational read port.
module aidc_lite_word_buf
  import aidc_lite_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_waddr,
  input  logic [CODE_WORD_W-1:0] i_wdata,
  input  logic [AW-1:0]          i_raddr,
  output logic [CODE_WORD_W-1:0] o_rdata
);

  logic [CODE_WORD_W-1:0] r_mem [DEPTH];

  // Contents are don't-care after reset, so the array carries no reset
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/aidc_lite_code_buf_ctrl.sv
// Sequences one line through encoder/concatenator, buffers code words, and
// streams either the compressed image or the raw line downstream.
module aidc_lite_code_buf_ctrl
  import aidc_lite_pkg::*;
#(
  parameter int WORD_DEPTH  = 16,
  parameter int RAW_WORDS   = 8,
  parameter int COMP_THRESH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   line_valid_i,
  input  logic [LINE_W-1:0]      line_data_i,
  output logic                   line_ready_o,
  output logic                   enc_start_o,
  input  logic                   cc_valid_i,
  input  logic [3:0]             cc_addr_i,
  input  logic [CODE_WORD_W-1:0] cc_data_i,
  input  logic                   cc_done_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [CODE_WORD_W-1:0] out_data_o,
  output logic                   out_last_o,
  output logic                   out_comp_o,
  output logic [3:0]             out_len_o,
  output logic                   err_o
);

  localparam logic [4:0] FULL_CNT   = 5'(WORD_DEPTH);
  localparam logic [4:0] THRESH_CNT = 5'(COMP_THRESH);
  localparam logic [3:0] RAW_LEN    = 4'(RAW_WORDS - 1);

  state_t              r_state;
  logic [LINE_W-1:0]   r_raw;
  logic [4:0]          r_count;
  logic                r_ovf;
  logic [3:0]          r_ptr;
  logic                r_line_ready;
  logic                r_enc_start;
  logic                r_out_valid;
  logic                r_out_last;
  logic                r_out_comp;
  logic [3:0]          r_out_len;
  logic                r_err;

  logic                   w_line_hs;
  logic                   w_in_fill;
  logic                   w_addr_ok;
  logic                   w_full;
  logic                   w_we;
  logic                   w_comp_dec;
  logic [3:0]             w_len_dec;
  logic                   w_out_hs;
  logic [CODE_WORD_W-1:0] w_buf_rdata;

  assign w_line_hs  = line_valid_i & r_line_ready;
  assign w_in_fill  = (r_state == FILL);
  assign w_addr_ok  = ({1'b0, cc_addr_i} == r_count);
  assign w_full     = (r_count == FULL_CNT);
  // Out-of-order addresses and writes past a full buffer never reach storage
  assign w_we       = w_in_fill & cc_valid_i & w_addr_ok & ~w_full;
  assign w_comp_dec = (r_count < THRESH_CNT) & ~r_ovf & (r_count != 5'd0);
  assign w_len_dec  = w_comp_dec ? (r_count[3:0] - 4'd1) : RAW_LEN;
  assign w_out_hs   = r_out_valid & out_ready_i;

  aidc_lite_word_buf #(
    .DEPTH (WORD_DEPTH),
    .AW    (4)
  ) u_word_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (cc_addr_i),
    .i_wdata (cc_data_i),
    .i_raddr (r_ptr),
    .o_rdata (w_buf_rdata)
  );

  // Control FSM with registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_count      <= 5'd0;
      r_ovf        <= 1'b0;
      r_ptr        <= 4'd0;
      r_line_ready <= 1'b1;
      r_enc_start  <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_comp   <= 1'b0;
      r_out_len    <= 4'd0;
      r_err        <= 1'b0;
    end else begin
      r_enc_start <= 1'b0;
      if (cc_valid_i && (!w_in_fill || !w_addr_ok)) begin
        r_err <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_line_hs) begin
            r_raw        <= line_data_i;
            r_count      <= 5'd0;
            r_ovf        <= 1'b0;
            r_enc_start  <= 1'b1;
            r_line_ready <= 1'b0;
            r_state      <= FILL;
          end
        end
        FILL: begin
          if (cc_valid_i) begin
            if (w_we) begin
              r_count <= r_count + 5'd1;
            end
            if (w_full) begin
              r_ovf <= 1'b1;
            end
            if (cc_done_i) begin
              r_state <= DECIDE;
            end
          end
        end
        DECIDE: begin
          r_out_comp  <= w_comp_dec;
          r_out_len   <= w_len_dec;
          r_ptr       <= 4'd0;
          r_out_valid <= 1'b1;
          r_out_last  <= (w_len_dec == 4'd0);
          r_state     <= DRAIN;
        end
        DRAIN: begin
          if (w_out_hs) begin
            if (r_out_last) begin
              r_out_valid  <= 1'b0;
              r_out_last   <= 1'b0;
              r_line_ready <= 1'b1;
              r_state      <= IDLE;
            end else begin
              r_ptr      <= r_ptr + 4'd1;
              r_out_last <= ((r_ptr + 4'd1) == r_out_len);
            end
          end
        end
        default: begin
          r_state      <= IDLE;
          r_line_ready <= 1'b1;
          r_out_valid  <= 1'b0;
          r_out_last   <= 1'b0;
        end
      endcase
    end
  end

  assign line_ready_o = r_line_ready;
  assign enc_start_o  = r_enc_start;
  assign out_valid_o  = r_out_valid;
  assign out_last_o   = r_out_last;
  assign out_comp_o   = r_out_comp;
  assign out_len_o    = r_out_len;
  assign err_o        = r_err;
  assign out_data_o   = r_out_comp ? w_buf_rdata : raw_word(r_raw, r_ptr[2:0]);

endmodule

// File: tb/tb_aidc_lite_code_buf_ctrl.sv
// Directed self-checking bench for aidc_lite_code_buf_ctrl.
module tb_aidc_lite_code_buf_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         line_valid;
  logic [511:0] line_data;
  logic         line_ready;
  logic         enc_start;
  logic         cc_valid;
  logic [3:0]   cc_addr;
  logic [63:0]  cc_data;
  logic         cc_done;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic         out_last;
  logic         out_comp;
  logic [3:0]   out_len;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_w [16];

  aidc_lite_code_buf_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .line_valid_i (line_valid),
    .line_data_i  (line_data),
    .line_ready_o (line_ready),
    .enc_start_o  (enc_start),
    .cc_valid_i   (cc_valid),
    .cc_addr_i    (cc_addr),
    .cc_data_i    (cc_data),
    .cc_done_i    (cc_done),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_last_o   (out_last),
    .out_comp_o   (out_comp),
    .out_len_o    (out_len),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] make_line(input logic [63:0] base);
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = base + 64'(k);
    return l;
  endfunction

  task automatic send_line(input logic [511:0] d, input string tag);
    line_data  = d;
    line_valid = 1'b1;
    check_eq({tag, "_rdy"}, 64'(line_ready), 64'd1);
    tick();
    line_valid = 1'b0;
    check_eq({tag, "_start"}, 64'(enc_start), 64'd1);
    check_eq({tag, "_rdy_lo"}, 64'(line_ready), 64'd0);
    tick();
    check_eq({tag, "_start_lo"}, 64'(enc_start), 64'd0);
  endtask

  task automatic cc_wr(input logic [3:0] a, input logic [63:0] d, input logic done);
    cc_valid = 1'b1;
    cc_addr  = a;
    cc_data  = d;
    cc_done  = done;
    tick();
    cc_valid = 1'b0;
    cc_done  = 1'b0;
  endtask

  // Checks one whole drain of n words against exp_w; bp selects ready pattern 1,0,0,1
  task automatic drain(input int n, input logic comp, input logic bp, input string tag);
    int idx = 0;
    int cyc = 0;
    logic rdy;
    while (idx < n && cyc < 200) begin
      rdy = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      out_ready = rdy;
      check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
      check_eq({tag, "_data"}, out_data, exp_w[idx]);
      check_eq({tag, "_last"}, 64'(out_last), 64'(idx == n - 1));
      check_eq({tag, "_comp"}, 64'(out_comp), 64'(comp));
      check_eq({tag, "_len"}, 64'(out_len), 64'(n - 1));
      check_eq({tag, "_lrdy"}, 64'(line_ready), 64'd0);
      if (rdy) idx++;
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    check_eq({tag, "_words"}, 64'(idx), 64'(n));
    check_eq({tag, "_end_valid"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_end_lrdy"}, 64'(line_ready), 64'd1);
  endtask

  // Short compressed line of n words using code words base+k
  task automatic comp_line(input int n, input logic [63:0] base, input string tag);
    send_line(make_line(64'h5555_0000_0000_0000), tag);
    for (int k = 0; k < n; k++) begin
      exp_w[k] = base + 64'(k);
      cc_wr(4'(k), base + 64'(k), k == n - 1);
    end
    check_eq({tag, "_decide"}, 64'(out_valid), 64'd0);
    tick();
    drain(n, 1'b1, 1'b0, tag);
  endtask

  initial begin
    rst = 1'b1; line_valid = 1'b0; line_data = '0; cc_valid = 1'b0;
    cc_addr = 4'd0; cc_data = 64'd0; cc_done = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_lrdy", 64'(line_ready), 64'd1);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_start", 64'(enc_start), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("rst_len", 64'(out_len), 64'd0);
    check_eq("rst_comp", 64'(out_comp), 64'd0);
    check_eq("rst_last", 64'(out_last), 64'd0);

    // Compressed 3-word image, first valid two cycles after final write
    comp_line(3, 64'hC0DE_0000_0000_0100, "comp3");

    // Count == threshold falls back to raw
    send_line(make_line(64'hA5A5_0000_0000_0000), "thr");
    for (int k = 0; k < 8; k++) cc_wr(4'(k), 64'hDEAD_0000_0000_0000 + 64'(k), k == 7);
    tick();
    for (int k = 0; k < 8; k++) exp_w[k] = 64'hA5A5_0000_0000_0000 + 64'(k);
    drain(8, 1'b0, 1'b0, "thr");
    check_eq("thr_err", 64'(err), 64'd0);

    // 17 writes: the 17th overflows and flags an error, raw image out
    send_line(make_line(64'h0F0F_0000_0000_0010), "ovf");
    for (int k = 0; k < 17; k++) begin
      cc_wr(4'(k), 64'hBEEF_0000_0000_0000 + 64'(k), k == 16);
      if (k == 15) check_eq("ovf_err_pre", 64'(err), 64'd0);
    end
    check_eq("ovf_err", 64'(err), 64'd1);
    tick();
    for (int k = 0; k < 8; k++) exp_w[k] = 64'h0F0F_0000_0000_0010 + 64'(k);
    drain(8, 1'b0, 1'b0, "ovf");
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("ovf_err_clr", 64'(err), 64'd0);

    // Backpressured 4-word drain; a new line is offered during the last handshake
    send_line(make_line(64'h1234_0000_0000_0000), "bp");
    for (int k = 0; k < 4; k++) begin
      exp_w[k] = 64'h7777_0000_0000_0040 + 64'(k);
      cc_wr(4'(k), exp_w[k], k == 3);
    end
    tick();
    line_data  = make_line(64'h9999_0000_0000_0000);
    line_valid = 1'b1;
    drain(4, 1'b1, 1'b1, "bp");
    check_eq("bp_no_accept", 64'(enc_start), 64'd0);

    // Reset while word 1 is presented
    send_line(make_line(64'h9999_0000_0000_0000), "rmd");
    for (int k = 0; k < 3; k++) cc_wr(4'(k), 64'h3333_0000_0000_0000 + 64'(k), k == 2);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("rmd_word1", out_data, 64'h3333_0000_0000_0001);
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("rmd_valid", 64'(out_valid), 64'd0);
    check_eq("rmd_lrdy", 64'(line_ready), 64'd1);
    check_eq("rmd_err", 64'(err), 64'd0);
    comp_line(2, 64'h4444_0000_0000_0000, "rmd_next");

    // Stray concatenator write while idle
    cc_wr(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    check_eq("stray_err", 64'(err), 64'd1);
    check_eq("stray_lrdy", 64'(line_ready), 64'd1);
    check_eq("stray_valid", 64'(out_valid), 64'd0);
    tick();
    comp_line(2, 64'h6666_0000_0000_0000, "stray_next");
    check_eq("stray_err_sticky", 64'(err), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aidc_lite_code_buf_ctrl.md
Name: aidc_lite_code_buf_ctrl

Overview:
- Sequences one cache line at a time through the AIDC-Lite encoder and code concatenator.
- Captures the concatenator's 64-bit code words into a 16-entry buffer and decides between the compressed image and the raw line.
- Streams the chosen image to the downstream link with valid/ready.
- The concatenator has no backpressure, so this block is the only flow-control point: it accepts a new line only when the previous one has fully drained.

Parameters:
- WORD_DEPTH, 16, code-word buffer entries (matches the 4-bit concatenator address).
- RAW_WORDS, 8, 64-bit words in a raw 512-bit line.
- COMP_THRESH, 8: compressed image used only if word count < COMP_THRESH; otherwise raw.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- line_valid_i  in  1  new raw line offered
- line_data_i  in  512  raw line; word k = bits [64k+63:64k]
- line_ready_o  out  1  line accepted when line_valid_i & line_ready_o
- enc_start_o  out  1  one-cycle pulse; starts the encoder (drives concatenator sop)
- cc_valid_i  in  1  concatenator word-write strobe
- cc_addr_i  in  4  concatenator word address
- cc_data_i  in  64  concatenator code word
- cc_done_i  in  1  concatenator done level; 1 together with the final cc_valid_i
- out_valid_o  out  1  output word valid
- out_ready_i  in  1  downstream accept
- out_data_o  out  64  output word
- out_last_o  out  1  final word of the image
- out_comp_o  out  1  1 = compressed image, 0 = raw
- out_len_o  out  4  image length in words minus 1; constant during drain
- err_o  out  1  sticky protocol error

Behaviour:
- Single clock domain (clk); rst is synchronous and active-high.
- Reset values:
  - FSM = IDLE; line_ready_o = 1
  - enc_start_o, out_valid_o, out_last_o, out_comp_o, err_o = 0
  - out_len_o = 0; word count = 0
  - Buffer contents are don't-care.
- Reset mid-operation aborts the line with no output; any partial drain is lost.
- FSM states: IDLE, FILL, DECIDE, DRAIN.
- IDLE:
  - line_ready_o = 1.
  - On handshake: latch line_data_i into the raw register, clear word count and overflow flag, pulse enc_start_o next cycle, go to FILL.
- FILL:
  - Each cc_valid_i: write cc_data_i to buf[cc_addr_i] and increment word count (5-bit, saturating at WORD_DEPTH).
  - A write when the count is already WORD_DEPTH sets overflow and is dropped.
  - cc_valid_i & cc_done_i in the same cycle: final word; write it, go to DECIDE.
  - cc_done_i without cc_valid_i is ignored.
- DECIDE (1 cycle): comp = (count < COMP_THRESH) & ~overflow & (count != 0).
  - comp: out_len_o = count - 1.
  - Otherwise: out_len_o = RAW_WORDS - 1, out_comp_o = 0.
  - Go to DRAIN with read pointer = 0.
- DRAIN:
  - out_valid_o = 1.
  - out_data_o = buf[ptr] if comp, else raw word ptr; read is combinational from registers.
  - out_last_o = (ptr == out_len_o).
  - On out_valid_o & out_ready_i: ptr++. On the last word go to IDLE; line_ready_o rises the following cycle.
  - While stalled, out_data_o, out_last_o, out_comp_o and out_len_o hold stable.
- Latency: accept → enc_start_o at +1 cycle. Final cc write → first out_valid_o at +2 cycles (DECIDE, then DRAIN).
- No concurrent lines; line_ready_o = 0 in FILL, DECIDE and DRAIN.
- Protocol errors set err_o (sticky until rst); the data is dropped and the FSM is unaffected:
  - cc_valid_i outside FILL
  - cc_addr_i != count on a write in FILL
- Simultaneous out handshake of the last word and a new line_valid_i: the line is not accepted that cycle.

Decomposition:
- Shared package aidc_lite_pkg holds:
  - state enum state_t {IDLE, FILL, DECIDE, DRAIN}
  - localparams CODE_WORD_W = 64, LINE_W = 512
  - the 2-bit prefix constant shared with the concatenator
- One sub-module, aidc_lite_word_buf: 16x64 register file with 1 write port and 1 combinational read port. FSM and counters stay in the top.

Test Plan:
- Compressed drain: line accepted; 3 cc writes at addr 0, 1, 2, done on the third → out_comp_o = 1, out_len_o = 2, 3 words in order, out_last_o on word 2, first out_valid_o 2 cycles after the final write.
- Threshold: 8 cc writes (count = 8 = COMP_THRESH) → out_comp_o = 0, out_len_o = 7, out_data_o = raw words 0..7 of line_data_i.
- Overflow: 17 writes (addr wraps after 15) → overflow, err_o = 1 on the 17th, raw image out, no buffer corruption visible.
- Backpressure: out_ready_i toggled 1,0,0,1,… during a 4-word compressed drain → every word held stable while stalled, each emitted exactly once, line_ready_o = 0 until the cycle after the last handshake.
- Reset mid-DRAIN: rst at word 1 → next cycle out_valid_o = 0, line_ready_o = 1, err_o = 0; the next line processes normally.
- Stray write: cc_valid_i in IDLE → err_o = 1, state stays IDLE, subsequent line unaffected.
